// File: rtl/clint_mtime_tick_if.sv
// Native valid/ready register bus shared with the CLINT.
// The master drives the request; the slave returns a one-cycle ready with registered rdata.
interface clint_mtime_tick_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  valid;
    logic [ADDR_W-1:0]     address;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic [DATA_W-1:0]     rdata;
    logic                  ready;

    modport master (
        output valid, address, wdata, wstrb,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wdata, wstrb,
        output rdata, ready
    );
endinterface

// File: rtl/clint_mtime_tick.sv
// mtime tick generator: programmable clk divider or synchronised rt_clk rising edge,
// with CTRL/DIV/TICKS/PCNT registers on the CLINT valid/ready bus.
module clint_mtime_tick #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DIV_W  = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    clint_mtime_tick_if.slave  bus,
    input  logic               i_rt_clk,
    output logic               o_mtime_tick
);

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_DIV   = 2'd1;
    localparam logic [1:0] A_TICKS = 2'd2;
    localparam logic [1:0] A_PCNT  = 2'd3;

    logic              r_ready;
    logic [DATA_W-1:0] r_rdata;
    logic              r_en;
    logic              r_src;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  r_cnt;
    logic [31:0]       r_ticks;
    logic              r_s1, r_s2, r_s3;
    logic              r_tick;

    logic              w_acc;
    logic              w_wr;
    logic              w_rd;
    logic [1:0]        w_sel;
    logic              w_cnt_clr;
    logic              w_edge;
    logic              w_cnt_wrap;
    logic              w_tick_nxt;
    logic [DATA_W-1:0] w_rdval;

    assign w_acc      = bus.valid & ~r_ready;
    assign w_wr       = w_acc & (bus.wstrb == '1);
    assign w_rd       = w_acc & (bus.wstrb == '0);
    assign w_sel      = bus.address[3:2];
    // Restart the divide period whenever its length or the tick source changes
    assign w_cnt_clr  = w_wr & ((w_sel == A_DIV) |
                                ((w_sel == A_CTRL) & (bus.wdata[1] != r_src)));
    assign w_edge     = r_s2 & ~r_s3;
    assign w_cnt_wrap = (r_cnt == r_div);
    assign w_tick_nxt = r_en & (r_src ? w_edge : w_cnt_wrap);

    always_comb begin
        w_rdval = '0;
        case (w_sel)
            A_CTRL:  w_rdval[1:0]       = {r_src, r_en};
            A_DIV:   w_rdval[DIV_W-1:0] = r_div;
            A_TICKS: w_rdval[31:0]      = r_ticks;
            A_PCNT:  w_rdval[DIV_W-1:0] = r_cnt;
            default: w_rdval = '0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_en    <= 1'b1;
            r_src   <= 1'b0;
            r_div   <= '0;
        end else begin
            r_ready <= w_acc;
            r_rdata <= w_rd ? w_rdval : '0;
            if (w_wr && w_sel == A_CTRL) begin
                r_en  <= bus.wdata[0];
                r_src <= bus.wdata[1];
            end
            if (w_wr && w_sel == A_DIV)
                r_div <= bus.wdata[DIV_W-1:0];
        end
    end

    // Synchroniser runs regardless of EN so re-enabling sees a settled history
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_rt_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cnt   <= '0;
            r_tick  <= 1'b0;
            r_ticks <= '0;
        end else begin
            r_tick <= w_tick_nxt;
            if (w_cnt_clr || !r_en || r_src || w_cnt_wrap)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;
            if (w_wr && w_sel == A_TICKS)
                r_ticks <= bus.wdata[31:0];
            else if (r_tick)
                r_ticks <= r_ticks + 32'd1;
        end
    end

    assign bus.ready    = r_ready;
    assign bus.rdata    = r_rdata;
    assign o_mtime_tick = r_tick;

endmodule

// File: tb/tb_clint_mtime_tick.sv
// Randomised bench for clint_mtime_tick against a cycle-level behavioural model,
// plus directed divider, RTC, wrap, strobe and async-reset scenarios.
module tb_clint_mtime_tick;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DIV_W  = 16;

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic rt_clk = 1'b0;
    logic tick;

    clint_mtime_tick_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    clint_mtime_tick #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .bus          (bus),
        .i_rt_clk     (rt_clk),
        .o_mtime_tick (tick)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural model
    bit        m_en = 1'b1, m_src = 1'b0, m_ready = 1'b0, m_tick = 1'b0;
    bit [15:0] m_div = '0, m_cnt = '0;
    bit [31:0] m_ticks = '0, m_rdata = '0;
    bit        samp[$] = '{1'b0, 1'b0, 1'b0, 1'b0};

    function automatic bit [31:0] m_read(input bit [1:0] s);
        case (s)
            2'd0:    return {30'd0, m_src, m_en};
            2'd1:    return {16'd0, m_div};
            2'd2:    return m_ticks;
            default: return {16'd0, m_cnt};
        endcase
    endfunction

    bit        t_acc, t_wr, t_rd, t_rise, t_tick;
    bit [1:0]  t_sel;
    int        t_phase;
    bit [15:0] t_cnt;
    bit [31:0] t_ticks;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en = 1'b1; m_src = 1'b0; m_div = '0; m_cnt = '0; m_ticks = '0;
            m_rdata = '0; m_ready = 1'b0; m_tick = 1'b0;
            samp = '{1'b0, 1'b0, 1'b0, 1'b0};
        end else begin
            t_acc = bus.valid && !m_ready;
            t_wr  = t_acc && bus.wstrb == 4'hF;
            t_rd  = t_acc && bus.wstrb == 4'h0;
            t_sel = bus.address[3:2];
            // rt_clk samples taken at each edge; a tick follows two edges after a 0->1 sample
            samp.push_back(rt_clk);
            if (samp.size() > 8) void'(samp.pop_front());
            t_rise = samp[samp.size()-3] && !samp[samp.size()-4];
            if (m_en && !m_src) begin
                t_phase = (int'(m_cnt) + 1) % (int'(m_div) + 1);
                t_tick  = (t_phase == 0);
            end else begin
                t_phase = 0;
                t_tick  = m_en && m_src && t_rise;
            end
            t_cnt = t_phase[15:0];
            if (t_wr && (t_sel == 2'd1 || (t_sel == 2'd0 && bus.wdata[1] != m_src)))
                t_cnt = '0;
            t_ticks = m_tick ? m_ticks + 32'd1 : m_ticks;
            if (t_wr && t_sel == 2'd2) t_ticks = bus.wdata;
            m_rdata = t_rd ? m_read(t_sel) : 32'd0;
            if (t_wr && t_sel == 2'd0) begin
                m_en  = bus.wdata[0];
                m_src = bus.wdata[1];
            end
            if (t_wr && t_sel == 2'd1) m_div = bus.wdata[15:0];
            m_cnt   = t_cnt;
            m_ticks = t_ticks;
            m_tick  = t_tick;
            m_ready = t_acc;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("tick", {31'd0, tick}, {31'd0, m_tick});
            chk("ready", {31'd0, bus.ready}, {31'd0, m_ready});
            chk("rdata", bus.rdata, m_rdata);
        end
    end

    // Background rt_clk generator; each phase lasts at least 2 clk cycles
    bit rt_auto = 1'b0;
    int rt_half = 0;
    int rt_left = 2;
    always @(negedge clk) begin
        if (rt_auto) begin
            if (rt_left <= 1) begin
                rt_clk  = ~rt_clk;
                rt_left = (rt_half != 0) ? rt_half : int'($urandom_range(2, 6));
            end else begin
                rt_left--;
            end
        end
    end

    task automatic bus_op(input bit [1:0] sel, input bit [31:0] wd, input bit [3:0] st,
                          output bit [31:0] rdv);
        bit got;
        got = 1'b0;
        rdv = '0;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = ($urandom() & 32'hFFFF_FFF3) | {28'd0, sel, 2'b00};
        bus.wdata   = wd;
        bus.wstrb   = st;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.ready) begin
                got = 1'b1;
                rdv = bus.rdata;
                break;
            end
        end
        if (!got) chk("bus_timeout", 32'd0, 32'd1);
        bus.valid = 1'b0;
        bus.wstrb = '0;
    endtask

    task automatic wr(input bit [1:0] sel, input bit [31:0] wd);
        bit [31:0] d;
        bus_op(sel, wd, 4'hF, d);
    endtask

    task automatic rd(input bit [1:0] sel, output bit [31:0] d);
        bus_op(sel, 32'd0, 4'h0, d);
    endtask

    task automatic count_ticks(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tick) n++;
        end
    endtask

    initial begin
        bit [31:0] d;
        int        n, lat;

        bus.valid = 1'b0; bus.address = '0; bus.wdata = '0; bus.wstrb = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // Free-running at clk after reset
        count_ticks(10, n);
        chk("reset_free_run", n, 10);
        rd(2'd0, d);
        chk("ctrl_reset", d, 32'h1);
        rd(2'd3, d);
        chk("pcnt_div0", d, 32'd0);

        // Divider N=4
        wr(2'd1, 32'd4);
        count_ticks(50, n);
        chk("div4_ticks", n, 10);
        rd(2'd1, d);
        chk("div_readback", d, 32'd4);

        // Partial strobe leaves DIV alone
        bus_op(2'd1, 32'h0000_0009, 4'h3, d);
        rd(2'd1, d);
        chk("partial_strobe", d, 32'd4);

        // RTC mode, latency from first high sample
        wr(2'd0, 32'h3);
        repeat (6) @(negedge clk);
        rt_clk = 1'b1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (tick && lat == 0) lat = i;
        end
        chk("rtc_latency", lat, 3);
        count_ticks(20, n);
        chk("rtc_held_high", n, 0);

        // Disable while rt_clk high, re-enable: no spurious tick
        wr(2'd0, 32'h0);
        repeat (4) @(negedge clk);
        wr(2'd0, 32'h3);
        count_ticks(10, n);
        chk("reenable_no_tick", n, 0);
        rt_clk = 1'b0;
        repeat (3) @(negedge clk);
        rt_clk = 1'b1;
        count_ticks(6, n);
        chk("fresh_edge_tick", n, 1);

        // 10-cycle-period rt_clk: one tick per rising edge
        rt_clk  = 1'b0;
        rt_half = 5;
        rt_left = 5;
        rt_auto = 1'b1;
        count_ticks(100, n);
        chk("rtc_period10", n, 10);
        rt_auto = 1'b0;

        // TICKS wrap with DIV=0
        wr(2'd0, 32'h1);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, d);
        chk("ticks_wrap_small", {31'd0, d < 32'd4}, 32'd1);
        wr(2'd2, 32'h1234_5678);
        rd(2'd2, d);
        chk("ticks_write_wins", {31'd0, (d - 32'h1234_5678) < 32'd4}, 32'd1);

        // Randomised traffic, rt_clk random phases
        rt_half = 0;
        rt_auto = 1'b1;
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0: begin
                    d = $urandom();
                    d[0] = ($urandom_range(0, 5) != 0);
                    wr(2'd0, d);
                end
                1, 2: begin
                    d = $urandom();
                    d[15:0] = 16'($urandom_range(0, 6));
                    wr(2'd1, d);
                end
                3: wr(2'd2, ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFE : $urandom());
                4, 5: rd(2'($urandom_range(0, 3)), d);
                6: bus_op(2'($urandom_range(0, 3)), $urandom(), 4'($urandom_range(1, 14)), d);
                7: wr(2'd3, $urandom());
                default: repeat ($urandom_range(1, 8)) @(negedge clk);
            endcase
        end
        rt_auto = 1'b0;

        // Asynchronous reset mid-divide
        wr(2'd0, 32'h1);
        wr(2'd1, 32'd2);
        repeat (7) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_tick", {31'd0, tick}, 32'd0);
        chk("arst_ready", {31'd0, bus.ready}, 32'd0);
        chk("arst_rdata", bus.rdata, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        rd(2'd1, d);
        chk("arst_div_cleared", d, 32'd0);
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
